// File: rtl/integration_pio_pkg.sv
// Shared definitions for the S4PU status input PIO: register map,
// edge-capture mode encodings and the post-reset arming states.
package integration_pio_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge capture mode (EDGE_TYPE parameter values)
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Post-reset arming: edges are ignored until the synchronizer has
    // flushed whatever level was present when reset was released.
    typedef enum logic {
        ARMING = 1'b0,
        ARMED  = 1'b1
    } arm_state_t;

endpackage

// File: rtl/integration_pio_sync_edge.sv
// Synchronizes the asynchronous status inputs, keeps a one-cycle delayed
// copy, runs the post-reset arm counter and produces the raw per-bit edge
// vector selected by EDGE_TYPE. The arm state is exported so the consumer
// can qualify edges and so the FSM is observable.
module integration_pio_sync_edge
    import integration_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_raw,
    output logic             arm_state
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 2);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    arm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronizer chain plus the previous-value register of its last stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Per-bit edge detect in the configured polarity
    always_comb begin
        edge_raw = sync & ~prev_q;
        if (EDGE_TYPE == EDGE_FALLING) begin
            edge_raw = ~sync & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_raw = sync ^ prev_q;
        end
    end

    // Arm FSM state and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARMING;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stay in ARMING for SYNC_STAGES+1 cycles (long enough for a level held
    // through reset to reach prev), then saturate in ARMED until next reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARMING: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SYNC_STAGES)) begin
                    state_d = ARMED;
                end
            end
            ARMED:   state_d = ARMED;
            default: state_d = ARMING;
        endcase
    end

    assign arm_state = state_q;

endmodule

// File: rtl/integration_pio_s4pu_status.sv
// Avalon-MM input PIO returning S4PU status bits to the Nios: synchronized
// DATA view, sticky per-bit edge capture (write-1-to-clear), maskable
// registered level interrupt.
//
// Bus access: a cycle with chipselect high and write_n low is exactly one
// write; a cycle with chipselect high and read_n low is exactly one read,
// its data presented on readdata on the following cycle and held until the
// next read. There are no wait states and no back-pressure; read and write
// never coincide.
module integration_pio_s4pu_status
    import integration_pio_pkg::*;
#(
    parameter int          WIDTH          = 16,
    parameter int          SYNC_STAGES    = 2,
    parameter int          EDGE_TYPE      = 0,
    parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_qual;
    logic             arm_state;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clear;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;
    logic             wdata_unused;

    integration_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .sync      (sync),
        .edge_raw  (edge_raw),
        .arm_state (arm_state)
    );

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & ~read_n;
    assign edge_qual    = (arm_state == ARMED) ? edge_raw : '0;
    assign cap_clear    = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign wdata_unused = ^writedata;

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= IRQ_MASK_RESET[WIDTH-1:0];
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge beats a same-cycle clear of that bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clear) | edge_qual;
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_cap & irq_mask);
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = 32'(sync);
            ADDR_RSVD:    rd_mux = '0;
            ADDR_IRQMASK: rd_mux = 32'(irq_mask);
            ADDR_EDGECAP: rd_mux = 32'(edge_cap);
            default:      rd_mux = '0;
        endcase
    end

    // Read data register, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

endmodule
